// File: rtl/io_pkg.sv
// io_pkg: shared helpers for the core I/O port controller.
// Address-width function and reset data constant.
package io_pkg;

    localparam int unsigned RST_WORD = 0;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// io_port_ctrl_if: core bus, producer streams and output lines
// of the I/O port controller; master = core/producers, slave = controller.
interface io_port_ctrl_if #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8
);
    import io_pkg::*;

    localparam int AIN = addr_w(NUIOIN);
    localparam int AOU = addr_w(NUIOOU);

    logic                       req_in;
    logic [AIN-1:0]             addr_in;
    logic [NUBITS-1:0]          io_in;
    logic                       out_en;
    logic [AOU-1:0]             addr_out;
    logic [NUBITS-1:0]          data_out;
    logic [NUIOIN*NUBITS-1:0]   in_data;
    logic [NUIOIN-1:0]          in_valid;
    logic [NUIOIN-1:0]          in_ready;
    logic [NUIOOU*NUBITS-1:0]   out_data;
    logic [NUIOOU-1:0]          out_valid;
    logic                       itr;
    logic [NUIOIN-1:0]          underflow;

    modport master (
        output req_in, addr_in, out_en, addr_out, data_out,
        output in_data, in_valid,
        input  io_in, in_ready, out_data, out_valid, itr, underflow
    );

    modport slave (
        input  req_in, addr_in, out_en, addr_out, data_out,
        input  in_data, in_valid,
        output io_in, in_ready, out_data, out_valid, itr, underflow
    );

endinterface

// File: rtl/io_fifo.sv
// io_fifo: first-word-fall-through buffer for one input channel.
// IO_FIFO_EN selects a 2^FDEPTH-entry FIFO; otherwise a single register.
module io_fifo #(
    parameter int NUBITS = 32,
    parameter int FDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [NUBITS-1:0] din,
    output logic [NUBITS-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic wr;
    logic rd;

    assign wr = push & ~full;
    assign rd = pop & ~empty;

`ifdef IO_FIFO_EN
    localparam int DEPTH = 1 << FDEPTH;

    logic [NUBITS-1:0] mem [DEPTH];
    logic [FDEPTH-1:0] wp;
    logic [FDEPTH-1:0] rp;
    logic [FDEPTH:0]   cnt;

    // pointers wrap naturally; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            if (wr && !rd) cnt <= cnt + 1'b1;
            else if (rd && !wr) cnt <= cnt - 1'b1;
        end
    end

    // storage needs no reset: empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign full  = cnt[FDEPTH];
    assign empty = (cnt == '0);
`else
    logic [NUBITS-1:0] data_q;
    logic              full_q;

    // single slot: load on push, free on pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr) begin
            data_q <= din;
            full_q <= 1'b1;
        end else if (rd) begin
            full_q <= 1'b0;
        end
    end

    assign dout  = data_q;
    assign full  = full_q;
    assign empty = ~full_q;
`endif

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: peripheral responder for the core I/O bus.
// Input buffering depth set by IO_FIFO_EN (see io_fifo).
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    io_port_ctrl_if.slave bus
);

    localparam int AIN = addr_w(NUIOIN);
    localparam int AOU = addr_w(NUIOOU);

    logic [NUIOIN-1:0] hit;
    logic [NUIOIN-1:0] push;
    logic [NUIOIN-1:0] pop;
    logic [NUIOIN-1:0] full;
    logic [NUIOIN-1:0] empty;
    logic [NUBITS-1:0] dout [NUIOIN];
    logic [NUBITS-1:0] hold [NUIOIN];
    logic [NUBITS-1:0] rd_word;

    logic [NUIOIN-1:0]        uf_q;
    logic                     itr_q;
    logic [NUIOOU*NUBITS-1:0] out_q;
    logic [NUIOOU-1:0]        ov_q;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_ch
        assign hit[k]  = bus.req_in && (bus.addr_in == AIN'(k));
        assign push[k] = bus.in_valid[k] & ~full[k];
        assign pop[k]  = hit[k] & ~empty[k];

        io_fifo #(
            .NUBITS (NUBITS),
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (bus.in_data[k*NUBITS +: NUBITS]),
            .dout  (dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // zero-latency read mux: head if buffered, else last popped word
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (bus.addr_in == AIN'(k)) begin
                rd_word = empty[k] ? hold[k] : dout[k];
            end
        end
    end

    // hold registers, sticky underflow and arrival interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                hold[k] <= NUBITS'(RST_WORD);
            end
            uf_q  <= '0;
            itr_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (pop[k]) hold[k] <= dout[k];
            end
            uf_q  <= uf_q | (hit & empty);
            itr_q <= |(push & empty);
        end
    end

    // registered output writes with one-cycle valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= {(NUIOOU*NUBITS){1'b0}};
            ov_q  <= '0;
        end else begin
            ov_q <= '0;
            for (int k = 0; k < NUIOOU; k++) begin
                if (bus.out_en && (bus.addr_out == AOU'(k))) begin
                    out_q[k*NUBITS +: NUBITS] <= bus.data_out;
                    ov_q[k]                   <= 1'b1;
                end
            end
        end
    end

    assign bus.io_in     = rd_word;
    assign bus.in_ready  = ~full;
    assign bus.underflow = uf_q;
    assign bus.itr       = itr_q;
    assign bus.out_data  = out_q;
    assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and randomized checks of io_port_ctrl
// against a queue-style reference model of the channel buffers.
module tb_io_port_ctrl;

    localparam int NUBITS = 32;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 2;
    localparam int AIN    = 3;
    localparam int AOU    = 3;
`ifdef IO_FIFO_EN
    localparam int DEPTH = 1 << FDEPTH;
`else
    localparam int DEPTH = 1;
`endif

    logic clk;
    logic rst;

    io_port_ctrl_if #(
        .NUBITS (NUBITS),
        .NUIOIN (NUIOIN),
        .NUIOOU (NUIOOU)
    ) bus ();

    io_port_ctrl #(
        .NUBITS (NUBITS),
        .NUIOIN (NUIOIN),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: per-channel list with front at index 0
    logic [NUBITS-1:0] m_buf  [NUIOIN][DEPTH];
    int                m_cnt  [NUIOIN];
    logic [NUBITS-1:0] m_hold [NUIOIN];
    logic [NUIOIN-1:0] m_uf;
    logic [NUBITS-1:0] m_out  [NUIOOU];
    logic [NUIOOU-1:0] m_ov;
    logic              m_itr;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NUIOIN; k++) begin
            m_cnt[k]  = 0;
            m_hold[k] = '0;
        end
        for (int k = 0; k < NUIOOU; k++) m_out[k] = '0;
        m_uf  = '0;
        m_ov  = '0;
        m_itr = 1'b0;
    endtask

    task automatic m_step();
        bit arrive;
        arrive = 1'b0;
        for (int k = 0; k < NUIOIN; k++) begin
            int  pre;
            bit  pushed;
            bit  reading;
            pre     = m_cnt[k];
            pushed  = bus.in_valid[k] && (pre < DEPTH);
            reading = bus.req_in && (int'(bus.addr_in) == k);
            if (reading && pre > 0) begin
                m_hold[k] = m_buf[k][0];
                for (int j = 0; j < DEPTH - 1; j++)
                    m_buf[k][j] = m_buf[k][j+1];
                m_cnt[k]--;
            end else if (reading) begin
                m_uf[k] = 1'b1;
            end
            if (pushed) begin
                if (pre == 0) arrive = 1'b1;
                m_buf[k][m_cnt[k]] = bus.in_data[k*NUBITS +: NUBITS];
                m_cnt[k]++;
            end
        end
        m_itr = arrive;
        m_ov  = '0;
        if (bus.out_en && int'(bus.addr_out) < NUIOOU) begin
            m_out[bus.addr_out] = bus.data_out;
            m_ov[bus.addr_out]  = 1'b1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // compare every cycle, away from the active edge
    initial begin
        forever begin
            logic [NUBITS-1:0]        e_io;
            logic [NUIOIN-1:0]        e_rdy;
            logic [NUIOOU*NUBITS-1:0] e_out;
            int                       a;
            @(negedge clk);
            #1;
            a = int'(bus.addr_in);
            if (a >= NUIOIN) e_io = '0;
            else if (m_cnt[a] > 0) e_io = m_buf[a][0];
            else e_io = m_hold[a];
            for (int k = 0; k < NUIOIN; k++) e_rdy[k] = (m_cnt[k] < DEPTH);
            for (int k = 0; k < NUIOOU; k++)
                e_out[k*NUBITS +: NUBITS] = m_out[k];
            chk("io_in",     256'(bus.io_in),     256'(e_io));
            chk("in_ready",  256'(bus.in_ready),  256'(e_rdy));
            chk("out_data",  256'(bus.out_data),  256'(e_out));
            chk("out_valid", 256'(bus.out_valid), 256'(m_ov));
            chk("itr",       256'(bus.itr),       256'(m_itr));
            chk("underflow", 256'(bus.underflow), 256'(m_uf));
        end
    end

    task automatic clr();
        bus.req_in   = 1'b0;
        bus.addr_in  = '0;
        bus.out_en   = 1'b0;
        bus.addr_out = '0;
        bus.data_out = '0;
        bus.in_data  = '0;
        bus.in_valid = '0;
    endtask

    task automatic put(input int ch, input logic [NUBITS-1:0] w);
        bus.in_valid[ch]                  = 1'b1;
        bus.in_data[ch*NUBITS +: NUBITS]  = w;
    endtask

    task automatic rd(input int ch);
        bus.req_in  = 1'b1;
        bus.addr_in = AIN'(ch);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'(8'hFF));
        chk("rst_io_in",    256'(bus.io_in),    256'(0));
        rst = 1'b0;

`ifdef IO_FIFO_EN
        @(negedge clk); clr(); put(2, 32'h11);
        @(negedge clk); clr(); put(2, 32'h22);
        @(negedge clk); clr(); put(2, 32'h33);
        @(negedge clk); clr(); rd(2); #1;
        chk("ch2_rd0", 256'(bus.io_in), 256'(32'h11));
        @(negedge clk); clr(); rd(2); #1;
        chk("ch2_rd1", 256'(bus.io_in), 256'(32'h22));
        @(negedge clk); clr(); rd(2); #1;
        chk("ch2_rd2", 256'(bus.io_in), 256'(32'h33));
        @(negedge clk); clr(); rd(2); #1;
        chk("ch2_rd_empty", 256'(bus.io_in), 256'(32'h33));
        @(negedge clk); clr(); #1;
        chk("ch2_underflow", 256'(bus.underflow), 256'(8'h04));
`else
        @(negedge clk); clr(); put(3, 32'hA);
        @(negedge clk); clr(); put(3, 32'hB); #1;
        chk("ch3_full", 256'(bus.in_ready[3]), 256'(0));
        @(negedge clk); clr(); put(3, 32'hB); rd(3); #1;
        chk("ch3_rdA", 256'(bus.io_in), 256'(32'hA));
        chk("ch3_refuse", 256'(bus.in_ready[3]), 256'(0));
        @(negedge clk); clr(); put(3, 32'hB); #1;
        chk("ch3_free", 256'(bus.in_ready[3]), 256'(1));
        @(negedge clk); clr(); rd(3); #1;
        chk("ch3_rdB", 256'(bus.io_in), 256'(32'hB));
`endif

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); clr(); put(0, 32'h100 + i);
        end
        @(negedge clk); clr(); put(0, 32'h99); rd(0); #1;
        chk("ch0_full", 256'(bus.in_ready[0]), 256'(0));
        chk("ch0_head", 256'(bus.io_in), 256'(32'h100));
        @(negedge clk); clr(); #1;
        chk("ch0_one_free", 256'(bus.in_ready[0]), 256'(1));
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk); clr(); rd(0); #1;
            chk("ch0_drain", 256'(bus.io_in), 256'(32'h100 + i));
        end
        @(negedge clk); clr(); #1;
        chk("ch0_no_push", 256'(bus.io_in), 256'(32'h100 + DEPTH - 1));

        @(negedge clk); clr();
        bus.out_en = 1'b1; bus.addr_out = 3'd5; bus.data_out = 32'hDEADBEEF;
        @(negedge clk); clr(); #1;
        chk("out5_data", 256'(bus.out_data[5*NUBITS +: NUBITS]),
            256'(32'hDEADBEEF));
        chk("out5_valid", 256'(bus.out_valid), 256'(8'b0010_0000));
        @(negedge clk); clr(); #1;
        chk("out5_pulse", 256'(bus.out_valid), 256'(0));

        @(negedge clk); clr(); put(1, 32'h1); put(4, 32'h4); #1;
        chk("itr_pre", 256'(bus.itr), 256'(0));
        @(negedge clk); clr(); #1;
        chk("itr_pulse", 256'(bus.itr), 256'(1));
        @(negedge clk); clr(); #1;
        chk("itr_one", 256'(bus.itr), 256'(0));

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = 1'b0;
            clr();
            for (int k = 0; k < NUIOIN; k++)
                bus.in_data[k*NUBITS +: NUBITS] = $urandom;
            if ((n / 500) % 2 == 0)
                bus.in_valid = NUIOIN'($urandom) & NUIOIN'($urandom);
            else
                bus.in_valid = NUIOIN'($urandom) | NUIOIN'($urandom);
            bus.req_in   = ($urandom_range(0, 2) != 0);
            bus.addr_in  = AIN'($urandom_range(0, NUIOIN - 1));
            bus.out_en   = $urandom_range(0, 1) == 1;
            bus.addr_out = AOU'($urandom_range(0, NUIOOU - 1));
            bus.data_out = $urandom;
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                chk("mid_rst_io_in",  256'(bus.io_in),     256'(0));
                chk("mid_rst_ready",  256'(bus.in_ready),  256'(8'hFF));
                chk("mid_rst_ov",     256'(bus.out_valid), 256'(0));
                chk("mid_rst_od",     256'(bus.out_data),  256'(0));
                chk("mid_rst_itr",    256'(bus.itr),       256'(0));
                chk("mid_rst_uf",     256'(bus.underflow), 256'(0));
            end
        end

        @(negedge clk); clr();
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
